// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The master drives the request side; the slave (the adder) drives the status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock, LSB first,
// through a ripple of DIGIT full-adder cells and a registered carry.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, psum, psum_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry, cout_q, ovf_q;
    logic [CNT_W-1:0] step;
    logic [DIGIT-1:0] digit_sum;
    logic [DIGIT:0]   chain_c;
    logic             accept, last_step;

    always_comb begin
        chain_c    = '0;
        digit_sum  = '0;
        chain_c[0] = carry;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            digit_sum[i]   = op_a[i] ^ op_b[i] ^ chain_c[i];
            chain_c[i + 1] = (op_a[i] & op_b[i]) | (chain_c[i] & (op_a[i] ^ op_b[i]));
        end
        // New digit enters at the MSB end so the completed word lands LSB-aligned.
        psum_next = (psum >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (step == CNT_W'(N - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            step   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_a  <= bus.a;
                op_b  <= bus.b;
                carry <= bus.cin;
                psum  <= '0;
                step  <= '0;
            end else if (state == RUN) begin
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                carry <= chain_c[DIGIT];
                psum  <= psum_next;
                step  <= step + 1'b1;
                if (last_step) begin
                    // On the final step the top chain cell is bit WIDTH-1.
                    sum_q  <= psum_next;
                    cout_q <= chain_c[DIGIT];
                    ovf_q  <= chain_c[DIGIT] ^ chain_c[DIGIT - 1];
                end
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 4/2) checked against
// an arithmetic reference of a + b + cin with signed-range overflow detection.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus0 ();
    serial_adder_if #(.WIDTH(8)) bus1 ();
    serial_adder_if #(.WIDTH(4)) bus2 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder #(.WIDTH(4), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int d, input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic c);
        case (d)
            0: begin bus0.start = s; bus0.a = av; bus0.b = bv; bus0.cin = c; end
            1: begin bus1.start = s; bus1.a = av; bus1.b = bv; bus1.cin = c; end
            default: begin bus2.start = s; bus2.a = av[3:0]; bus2.b = bv[3:0]; bus2.cin = c; end
        endcase
    endtask

    task automatic get_out(input int d, output logic bz, output logic dn, output logic [7:0] sm,
                           output logic co, output logic ov);
        case (d)
            0: begin bz = bus0.busy; dn = bus0.done; sm = bus0.sum; co = bus0.cout; ov = bus0.overflow; end
            1: begin bz = bus1.busy; dn = bus1.done; sm = bus1.sum; co = bus1.cout; ov = bus1.overflow; end
            default: begin
                bz = bus2.busy; dn = bus2.done; sm = {4'h0, bus2.sum}; co = bus2.cout; ov = bus2.overflow;
            end
        endcase
    endtask

    // Reference: unsigned total for sum/cout, signed total range test for overflow.
    task automatic model(input int w, input int av, input int bv, input int c,
                         output int sm, output int co, output int ov);
        int total, sa, sb, st;
        total = av + bv + c;
        sm    = total % (1 << w);
        co    = total >> w;
        sa    = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb    = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        st    = sa + sb + c;
        ov    = (st > (1 << (w - 1)) - 1 || st < -(1 << (w - 1))) ? 1 : 0;
    endtask

    task automatic run_add(input int d, input logic [7:0] av, input logic [7:0] bv, input logic c,
                           input int n);
        logic bz, dn, co, ov;
        logic [7:0] sm;
        int cyc, busy_cnt, esum, ecout, eovf, w;
        w = (d == 2) ? 4 : 8;
        @(negedge clk);
        set_in(d, 1'b1, av, bv, c);
        @(posedge clk);
        #1;
        set_in(d, 1'b0, ~av, ~bv, ~c);
        cyc = 0;
        busy_cnt = 0;
        get_out(d, bz, dn, sm, co, ov);
        while (!dn && cyc < n + 4) begin
            if (bz) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
            get_out(d, bz, dn, sm, co, ov);
        end
        model(w, int'(av), int'(bv), int'(c), esum, ecout, eovf);
        check("latency", cyc, n);
        check("busy_cycles", busy_cnt, n);
        check("busy_with_done", bz, 1'b0);
        check("sum", sm, esum);
        check("cout", co, ecout);
        check("overflow", ov, eovf);
        @(posedge clk);
        #1;
        get_out(d, bz, dn, sm, co, ov);
        check("done_one_cycle", dn, 1'b0);
        check("sum_held", sm, esum);
    endtask

    initial begin
        logic bz, dn, co, ov;
        logic [7:0] sm;
        int cyc, done_seen;

        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            get_out(d, bz, dn, sm, co, ov);
            check("rst_busy", bz, 1'b0);
            check("rst_done", dn, 1'b0);
            check("rst_sum", sm, 8'h00);
            check("rst_cout", co, 1'b0);
            check("rst_ovf", ov, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_add(0, 8'h3C, 8'h15, 1'b0, 8);
        run_add(0, 8'hFF, 8'h00, 1'b1, 8);
        run_add(1, 8'h7F, 8'h01, 1'b0, 2);
        run_add(1, 8'h80, 8'h80, 1'b0, 2);

        for (int k = 0; k < 12; k++) begin
            run_add(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8);
            run_add(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2);
        end

        // Mid-run start ignored, then start held through DONE for a back-to-back run.
        @(negedge clk);
        set_in(0, 1'b1, 8'h01, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'h01, 8'h01, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b1, 8'hAA, 8'hAA, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'hAA, 8'hAA, 1'b0);
        @(negedge clk);
        set_in(0, 1'b1, 8'h10, 8'h20, 1'b0);
        cyc = 0;
        get_out(0, bz, dn, sm, co, ov);
        while (!dn && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            get_out(0, bz, dn, sm, co, ov);
        end
        check("hs_first_done", dn, 1'b1);
        check("hs_first_sum", sm, 8'h02);
        check("hs_first_cout", co, 1'b0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        get_out(0, bz, dn, sm, co, ov);
        check("hs_b2b_busy", bz, 1'b1);
        check("hs_b2b_done_low", dn, 1'b0);
        cyc = 0;
        while (!dn && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            get_out(0, bz, dn, sm, co, ov);
        end
        check("hs_second_latency", cyc, 8);
        check("hs_second_sum", sm, 8'h30);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        set_in(0, 1'b1, 8'h3C, 8'h15, 1'b0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        get_out(0, bz, dn, sm, co, ov);
        check("mid_rst_busy", bz, 1'b0);
        check("mid_rst_done", dn, 1'b0);
        check("mid_rst_sum", sm, 8'h00);
        check("mid_rst_cout", co, 1'b0);
        check("mid_rst_ovf", ov, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            get_out(0, bz, dn, sm, co, ov);
            if (dn || bz) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        run_add(0, 8'h05, 8'h06, 1'b0, 8);

        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int c = 0; c < 2; c++)
                    run_add(2, 8'(av), 8'(bv), 1'(c), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder built from a chain of DIGIT full-adder cells plus a registered carry. It adds two WIDTH-bit operands DIGIT bits per clock, LSB first, under a start/busy/done handshake. It extends the single-bit full adder to arbitrary operand widths while keeping the combinational path to DIGIT cells. It is the arithmetic unit for the lab's datapath blocks where area matters more than latency.

## Interface

- WIDTH, 8, operand and result width in bits; must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 1, bits added per clock (full-adder cells in the chain); 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request an addition; sampled only when busy = 0.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse marking the cycle a new result becomes valid.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH; held until the next result.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into bit WIDTH-1 XOR cout.

## Operation

- N = WIDTH/DIGIT digit steps per addition.
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1. A step counter counts 0..N-1.
  - DONE: busy = 0, done = 1, for exactly one cycle.
- IDLE or DONE, start = 1 → RUN.
  - Capture a, b and cin into the operand shift registers and carry flop.
  - Clear the step counter.
- IDLE or DONE, start = 0 → IDLE.
- Each RUN cycle:
  - Add the DIGIT LSBs of both shift registers plus the carry flop through a ripple of full-adder cells.
  - Shift the DIGIT sum bits into the MSB end of a partial-sum register.
  - Shift both operand registers right by DIGIT.
  - Update the carry flop with the chain carry-out.
  - Record the carry into the top cell; this is needed for overflow on the last step.
- RUN, step = N-1 → DONE.
  - On the same edge, load sum, cout and overflow from the completed partial-sum and carry values.
- start while busy = 1 is ignored. No queueing; operands are not re-sampled.
- a, b and cin may change freely after the accepting edge without affecting the result.
- sum, cout and overflow change only on the edge that enters DONE. They are stable at all other times.
- Reset (rst_n = 0), at any time including mid-RUN:
  - State → IDLE, step counter → 0, internal registers → 0.
  - busy = 0, done = 0, sum = 0, cout = 0, overflow = 0.
  - Any in-flight addition is discarded, and no done is produced for it.
- Release of reset behaves as IDLE with start sampled on the first rising edge.

## Timing

- Accepting edge E0: start = 1 and busy = 0 sampled.
- busy is high in the N cycles after E0 (edges E0+1 … E0+N perform the steps).
- The result registers load at edge E0+N.
- done is high for the one cycle following edge E0+N. sum, cout and overflow are valid from that cycle onward.
- Latency from accepting edge to done = N cycles.
- Back-to-back: start held high during the DONE cycle is accepted. Throughput is one result per N+1 cycles.
- busy and done are never high together.
- Special cases:
  - N = 1 (DIGIT = WIDTH): RUN lasts one cycle, and the block degenerates to a registered adder with 1-cycle latency.
  - Maximum combinational depth is DIGIT full-adder cells plus the shift/mux logic.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Test plan

- WIDTH = 8, DIGIT = 1: a = 0x3C, b = 0x15, cin = 0.
  - Expect busy high for exactly 8 cycles.
  - Expect done pulsing 8 cycles after the accepting edge.
  - Expect sum = 0x51, cout = 0, overflow = 0.
- WIDTH = 8, DIGIT = 1: a = 0xFF, b = 0x00, cin = 1 → sum = 0x00, cout = 1, overflow = 0. This checks full carry ripple through the serial carry flop.
- WIDTH = 8, DIGIT = 4, signed overflow cases:
  - a = 0x7F, b = 0x01, cin = 0 → done after 2 cycles, sum = 0x80, cout = 0, overflow = 1.
  - a = 0x80, b = 0x80 → sum = 0x00, cout = 1, overflow = 1.
- Handshake:
  - Pulse start with a = 0x01, b = 0x01.
  - Change a and b to 0xAA and reassert start mid-RUN → sum = 0x02, and the mid-run start is ignored.
  - Hold start high through DONE with a = 0x10, b = 0x20 → second run is accepted with no IDLE gap, and second done gives sum = 0x30.
- Reset:
  - Assert rst_n = 0 asynchronously at step 3 of a run → busy, done, sum, cout and overflow go to 0 immediately, and no done follows.
  - After release, a fresh add 0x05 + 0x06 gives sum = 0x0B.
- Exhaustive: WIDTH = 4, DIGIT = 2, all 512 combinations of a, b and cin, each compared against a reference model (a + b + cin) for sum, cout and overflow.
